vld_unit_strided: RTL and testbench

Parametrised vector-load sequencer and successor to the single-width masked load unit. It accepts one load request: base beat address, VL, destination vreg, SEW, beat stride and mask controls. It then issues one beat per accepted handshake, driving a memory beat address, a VRF (or mask-register) write address and per-byte write enables. Adds over the previous generation:
- runtime SEW with element-to-byte mask expansion
- non-unit beat stride
- real backpressure on the beat channel
- VL clamping
- a done pulse

---
 rtl/vld_pkg.sv | 31 +++
 rtl/vld_mask_expand.sv | 24 ++
 rtl/vld_unit_strided.sv | 146 ++++++++++++++
 tb/tb_vld_unit_strided.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vld_pkg.sv
// rtl/vld_pkg.sv - shared types and sizing helpers for the vector-load sequencer
package vld_pkg;

   typedef enum logic [1:0] {
      SEW8  = 2'd0,
      SEW16 = 2'd1,
      SEW32 = 2'd2,
      SEW64 = 2'd3
   } sew_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      DONE = 2'd2
   } state_e;

   // Elements per beat for a given element width.
   function automatic int unsigned epb(input sew_e sew, input int unsigned data_bytes);
      return data_bytes >> sew;
   endfunction

   // Live bytes in a beat holding r remaining elements (r saturates at one full beat).
   function automatic int unsigned tail_bytes(input int unsigned r, input sew_e sew,
                                              input int unsigned data_bytes);
      int unsigned n;
      n = epb(sew, data_bytes);
      if (r < n) n = r;
      return n << sew;
   endfunction

endpackage

// File: rtl/vld_mask_expand.sv
// rtl/vld_mask_expand.sv - replicates each element mask bit over that element's bytes
module vld_mask_expand
   import vld_pkg::*;
#(
   parameter int DATA_BYTES = 8
) (
   input  logic [DATA_BYTES-1:0] elem_mask,
   input  sew_e                  sew,
   output logic [DATA_BYTES-1:0] byte_en
);

   localparam int IDXW = $clog2(DATA_BYTES);

   logic [IDXW-1:0] idx [DATA_BYTES];

   always_comb begin
      byte_en = '0;
      for (int unsigned j = 0; j < DATA_BYTES; j++) begin
         idx[j]     = IDXW'(j >> sew);
         byte_en[j] = elem_mask[idx[j]];
      end
   end

endmodule

// File: rtl/vld_unit_strided.sv
// rtl/vld_unit_strided.sv - vector-load beat sequencer with SEW masks and VL clamp; VLD_STRIDE_EN enables non-unit stride
module vld_unit_strided
   import vld_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_BYTES  = 8,
   parameter int VLMAX_BEATS = 32,
   parameter int VREG_WIDTH  = 5,
   parameter int VL_WIDTH    = 32
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      req_valid,
   output logic                                      req_ready,
   input  logic [ADDR_WIDTH-1:0]                     req_addr,
   input  logic [VL_WIDTH-1:0]                       req_vl,
   input  logic [VREG_WIDTH-1:0]                     req_vr,
   input  logic [1:0]                                req_sew,
   input  logic [ADDR_WIDTH-1:0]                     req_stride,
   input  logic                                      req_masked,
   input  logic                                      req_mask_dst,
   output logic [VL_WIDTH-1:0]                       mask_elem_idx,
   input  logic [DATA_BYTES-1:0]                     mask_in,
   output logic                                      beat_valid,
   input  logic                                      beat_ready,
   output logic [ADDR_WIDTH-1:0]                     addr_mm,
   output logic [VREG_WIDTH+$clog2(VLMAX_BEATS)-1:0] addr_vrf,
   output logic [DATA_BYTES-1:0]                     b_en,
   output logic                                      wr_vrf,
   output logic                                      wr_mask,
   output logic                                      done
);

   localparam int VRF_AW = VREG_WIDTH + $clog2(VLMAX_BEATS);
   localparam logic [VL_WIDTH-1:0] VLMAX_ELEMS = VL_WIDTH'(VLMAX_BEATS * DATA_BYTES);

   state_e                  state, state_next;
   sew_e                    sew_q;
   logic                    masked_q, mask_dst_q;
   logic [VL_WIDTH-1:0]     rem_q;
   logic [VL_WIDTH-1:0]     vl_cap, vl_eff, cur_epb;
   logic [ADDR_WIDTH-1:0]   addr_inc;
   logic                    accept, beat_fire, last_beat;
   logic [31:0]             tail_r;
   int unsigned             tail_cnt;
   logic [DATA_BYTES-1:0]   expanded, elem_en, tail_en;

`ifdef VLD_STRIDE_EN
   logic [ADDR_WIDTH-1:0]   stride_q;
   assign addr_inc = stride_q;
`else
   logic                    unused_stride;
   assign unused_stride = ^req_stride;
   assign addr_inc      = ADDR_WIDTH'(1);
`endif

   assign accept    = req_valid & req_ready;
   assign beat_fire = beat_valid & beat_ready;
   assign vl_cap    = VLMAX_ELEMS >> req_sew;
   assign vl_eff    = (req_vl > vl_cap) ? vl_cap : req_vl;
   assign cur_epb   = VL_WIDTH'(epb(sew_q, DATA_BYTES));
   // rem_q holds elements still to deliver, so the final beat is the one covering the rest.
   assign last_beat = (rem_q <= cur_epb);
   assign tail_r    = last_beat ? 32'(rem_q) : 32'(cur_epb);
   assign tail_cnt  = tail_bytes(tail_r, sew_q, DATA_BYTES);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      beat_valid = 1'b0;
      done       = 1'b0;
      wr_vrf     = 1'b0;
      wr_mask    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (accept) state_next = (vl_eff == '0) ? DONE : BEAT;
         end
         BEAT: begin
            beat_valid = 1'b1;
            wr_vrf     = ~mask_dst_q;
            wr_mask    = mask_dst_q;
            if (beat_fire && last_beat) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_mm       <= '0;
         addr_vrf      <= '0;
         mask_elem_idx <= '0;
         rem_q         <= '0;
         sew_q         <= SEW8;
         masked_q      <= 1'b0;
         mask_dst_q    <= 1'b0;
`ifdef VLD_STRIDE_EN
         stride_q      <= '0;
`endif
      end else if (accept) begin
         addr_mm       <= req_addr;
         addr_vrf      <= VRF_AW'(req_vr) * VRF_AW'(VLMAX_BEATS);
         mask_elem_idx <= '0;
         rem_q         <= vl_eff;
         sew_q         <= sew_e'(req_sew);
         masked_q      <= req_masked;
         mask_dst_q    <= req_mask_dst;
`ifdef VLD_STRIDE_EN
         stride_q      <= req_stride;
`endif
      end else if (beat_fire && !last_beat) begin
         addr_mm       <= addr_mm + addr_inc;
         addr_vrf      <= addr_vrf + VRF_AW'(1);
         mask_elem_idx <= mask_elem_idx + cur_epb;
         rem_q         <= rem_q - cur_epb;
      end
   end

   vld_mask_expand #(
      .DATA_BYTES(DATA_BYTES)
   ) u_mask_expand (
      .elem_mask(mask_in),
      .sew      (sew_q),
      .byte_en  (expanded)
   );

   always_comb begin
      tail_en = '0;
      for (int unsigned j = 0; j < DATA_BYTES; j++) begin
         if (j < tail_cnt) tail_en[j] = 1'b1;
      end
      elem_en = masked_q ? expanded : '1;
      b_en    = beat_valid ? (tail_en & elem_en) : '0;
   end

endmodule

// File: tb/tb_vld_unit_strided.sv
// tb/tb_vld_unit_strided.sv - scoreboard bench for vld_unit_strided; honours VLD_STRIDE_EN
module tb_vld_unit_strided;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [31:0] req_vl = '0;
   logic [4:0]  req_vr = '0;
   logic [1:0]  req_sew = '0;
   logic [31:0] req_stride = '0;
   logic        req_masked = 1'b0;
   logic        req_mask_dst = 1'b0;
   logic [31:0] mask_elem_idx;
   logic [7:0]  mask_in;
   logic        beat_valid;
   logic        beat_ready = 1'b1;
   logic [31:0] addr_mm;
   logic [9:0]  addr_vrf;
   logic [7:0]  b_en;
   logic        wr_vrf, wr_mask, done;

   always #5 clk = ~clk;

   vld_unit_strided dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_vl(req_vl), .req_vr(req_vr), .req_sew(req_sew),
      .req_stride(req_stride), .req_masked(req_masked), .req_mask_dst(req_mask_dst),
      .mask_elem_idx(mask_elem_idx), .mask_in(mask_in), .beat_valid(beat_valid),
      .beat_ready(beat_ready), .addr_mm(addr_mm), .addr_vrf(addr_vrf), .b_en(b_en),
      .wr_vrf(wr_vrf), .wr_mask(wr_mask), .done(done)
   );

   typedef struct {
      logic [31:0] a;
      logic [9:0]  v;
      logic [7:0]  b;
      logic        wv;
      logic        wm;
      logic [31:0] e;
   } exp_t;

   exp_t         sb[$];
   exp_t         got;
   logic [255:0] v0 = '0;
   int           vectors = 0, miscompares = 0;
   int           cyc = 0, hs_cnt = 0, done_cnt = 0;
   int           last_hs_cyc = 0, done_cyc = 0, acc_cyc = 0;
   logic         done_rr = 1'b0;
   int           bp_mode = 0;

   always @(posedge clk) cyc = cyc + 1;

   // v0 mask register model: returns bits starting at the element index the DUT asks for.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         if ((mask_elem_idx + 32'(i)) < 32'd256) mask_in[i] = v0[8'(mask_elem_idx + 32'(i))];
         else                                    mask_in[i] = 1'b0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (bp_mode == 1) beat_ready = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (beat_valid && beat_ready) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            if (sb.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL beat_unexpected addr_mm=%h addr_vrf=%0d", addr_mm, addr_vrf);
            end else begin
               got = sb.pop_front();
               vectors++;
               if (addr_mm !== got.a) begin miscompares++; $display("FAIL addr_mm got=%h exp=%h", addr_mm, got.a); end
               vectors++;
               if (addr_vrf !== got.v) begin miscompares++; $display("FAIL addr_vrf got=%0d exp=%0d", addr_vrf, got.v); end
               vectors++;
               if (b_en !== got.b) begin miscompares++; $display("FAIL b_en got=%h exp=%h @addr %h", b_en, got.b, got.a); end
               vectors++;
               if (wr_vrf !== got.wv || wr_mask !== got.wm) begin
                  miscompares++; $display("FAIL wr_flags got=%b%b exp=%b%b", wr_vrf, wr_mask, got.wv, got.wm);
               end
               vectors++;
               if (mask_elem_idx !== got.e) begin miscompares++; $display("FAIL mask_elem_idx got=%0d exp=%0d", mask_elem_idx, got.e); end
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_rr  = req_ready;
         end
      end
   end

   // Element-level reference: byte j of beat k is live iff its element is inside VL and unmasked.
   task automatic push_model(input logic [31:0] addr, input int unsigned vl, input int unsigned vr,
                             input int unsigned sew, input logic [31:0] stride, input bit masked,
                             input bit mdst, output int nb);
      int unsigned epb_m, vle, el;
      logic [31:0] st;
      exp_t x;
      epb_m = 8 >> sew;
      vle   = (vl > 32 * epb_m) ? 32 * epb_m : vl;
      nb    = int'((vle + epb_m - 1) / epb_m);
`ifdef VLD_STRIDE_EN
      st = stride;
`else
      st = 32'd1;
`endif
      for (int k = 0; k < nb; k++) begin
         x.a  = addr + 32'(k) * st;
         x.v  = 10'(vr * 32 + 32'(k));
         x.e  = 32'(k) * epb_m;
         x.wv = !mdst;
         x.wm = mdst;
         for (int j = 0; j < 8; j++) begin
            el = 32'(k) * epb_m + (32'(j) >> sew);
            x.b[j] = (el < vle) && (!masked || v0[8'(el)]);
         end
         sb.push_back(x);
      end
   endtask

   task automatic send_req(input logic [31:0] addr, input int unsigned vl, input int unsigned vr,
                           input int unsigned sew, input logic [31:0] stride, input bit masked,
                           input bit mdst, output int nb);
      int t = 0;
      @(posedge clk); #1;
      while (!req_ready && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) begin
         vectors++; miscompares++;
         $display("FAIL req_ready_timeout got=%b exp=1", req_ready);
      end
      push_model(addr, vl, vr, sew, stride, masked, mdst, nb);
      req_addr = addr; req_vl = vl; req_vr = 5'(vr); req_sew = 2'(sew);
      req_stride = stride; req_masked = masked; req_mask_dst = mdst;
      req_valid = 1'b1;
      acc_cyc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic finish_req(input int nb, input int hs0, input int dc0);
      int t = 0;
      int exp_d;
      while (done_cnt == dc0 && t < 3000) begin @(posedge clk); t++; end
      vectors++;
      if (done_cnt != dc0 + 1) begin
         miscompares++; $display("FAIL done_count got=%0d exp=%0d", done_cnt - dc0, 1);
      end else begin
         exp_d = (nb == 0) ? acc_cyc + 1 : last_hs_cyc + 1;
         vectors++;
         if (done_cyc != exp_d) begin miscompares++; $display("FAIL done_timing got=%0d exp=%0d", done_cyc, exp_d); end
         vectors++;
         if (done_rr !== 1'b0) begin miscompares++; $display("FAIL ready_during_done got=%b exp=0", done_rr); end
         #1;
         vectors++;
         if (req_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++; $display("FAIL ready_after_done got=%b%b exp=10", req_ready, done);
         end
      end
      vectors++;
      if (hs_cnt - hs0 != nb) begin miscompares++; $display("FAIL beat_count got=%0d exp=%0d", hs_cnt - hs0, nb); end
      vectors++;
      if (sb.size() != 0) begin miscompares++; $display("FAIL beats_missing got=%0d exp=0", sb.size()); sb.delete(); end
   endtask

   task automatic check_idle_outputs(input string tag);
      vectors++;
      if (req_ready !== 1'b1 || beat_valid !== 1'b0 || done !== 1'b0 || wr_vrf !== 1'b0 ||
          wr_mask !== 1'b0 || addr_mm !== '0 || addr_vrf !== '0 || b_en !== '0 || mask_elem_idx !== '0) begin
         miscompares++;
         $display("FAIL %s got rdy=%b bv=%b dn=%b wv=%b wm=%b am=%h av=%0d be=%h mi=%0d exp reset values",
                  tag, req_ready, beat_valid, done, wr_vrf, wr_mask, addr_mm, addr_vrf, b_en, mask_elem_idx);
      end
   endtask

   task automatic test_reset();
      #2;
      check_idle_outputs("reset_held");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset_released");
   endtask

   task automatic test_basic();
      int nb, hs0, dc0;
      bp_mode = 0; beat_ready = 1'b1; v0 = '0;
      hs0 = hs_cnt; dc0 = done_cnt;
      send_req(32'h100, 20, 3, 0, 32'd1, 1'b0, 1'b0, nb);
      finish_req(nb, hs0, dc0);
   endtask

   task automatic test_vl_zero();
      int nb, hs0, dc0;
      hs0 = hs_cnt; dc0 = done_cnt;
      send_req(32'h180, 0, 2, 1, 32'd1, 1'b0, 1'b0, nb);
      finish_req(nb, hs0, dc0);
   endtask

   task automatic test_masked();
      int nb, hs0, dc0;
      v0 = '0;
      v0[1] = 1'b1; v0[2] = 1'b1; v0[3] = 1'b1;
      hs0 = hs_cnt; dc0 = done_cnt;
      send_req(32'h40, 3, 2, 2, 32'd1, 1'b1, 1'b1, nb);
      finish_req(nb, hs0, dc0);
   endtask

   task automatic test_backpressure();
      int nb, hs0, dc0, t;
      v0 = '0; beat_ready = 1'b1;
      hs0 = hs_cnt; dc0 = done_cnt;
      send_req(32'h100, 20, 3, 0, 32'd1, 1'b0, 1'b0, nb);
      t = 0;
      while (!(beat_valid && addr_mm == 32'h101) && t < 50) begin @(posedge clk); #1; t++; end
      beat_ready = 1'b0;
      vectors++;
      if (t >= 50) begin miscompares++; $display("FAIL stall_beat_timeout got=%h exp=%h", addr_mm, 32'h101); end
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (beat_valid !== 1'b1 || addr_mm !== 32'h101 || addr_vrf !== 10'd97 || b_en !== 8'hFF) begin
            miscompares++;
            $display("FAIL stall_hold got bv=%b am=%h av=%0d be=%h exp 1/101/97/ff", beat_valid, addr_mm, addr_vrf, b_en);
         end
         @(posedge clk); #1;
      end
      beat_ready = 1'b1;
      finish_req(nb, hs0, dc0);
   endtask

   task automatic test_stride();
      int nb, hs0, dc0;
      v0 = '0;
      hs0 = hs_cnt; dc0 = done_cnt;
      send_req(32'hFFFF_FFFC, 3, 1, 3, 32'd4, 1'b0, 1'b0, nb);
      finish_req(nb, hs0, dc0);
      hs0 = hs_cnt; dc0 = done_cnt;
      send_req(32'h200, 1000, 31, 0, 32'd2, 1'b0, 1'b0, nb);
      finish_req(nb, hs0, dc0);
   endtask

   task automatic test_reset_mid();
      int nb, hs0, dc0, t;
      beat_ready = 1'b1;
      dc0 = done_cnt;
      send_req(32'h300, 20, 4, 0, 32'd1, 1'b0, 1'b0, nb);
      t = 0;
      while (!(beat_valid && addr_mm == 32'h301) && t < 50) begin @(posedge clk); #1; t++; end
      #2 rst = 1'b1;
      sb.delete();
      #1;
      check_idle_outputs("reset_mid_request");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      vectors++;
      if (done_cnt != dc0) begin miscompares++; $display("FAIL done_after_abort got=%0d exp=%0d", done_cnt - dc0, 0); end
      hs0 = hs_cnt; dc0 = done_cnt;
      send_req(32'h100, 20, 3, 0, 32'd1, 1'b0, 1'b0, nb);
      finish_req(nb, hs0, dc0);
   endtask

   task automatic test_back_to_back();
      int nb, hs0, dc0;
      int unsigned vl;
      bp_mode = 1;
      for (int r = 0; r < 10; r++) begin
         v0 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         vl = (r == 3) ? 300 : $urandom_range(0, 40);
         hs0 = hs_cnt; dc0 = done_cnt;
         send_req($urandom(), vl, $urandom_range(0, 31), $urandom_range(0, 3), 32'($urandom_range(0, 9)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nb);
         finish_req(nb, hs0, dc0);
      end
      bp_mode = 0;
      beat_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_vl_zero();
      test_masked();
      test_backpressure();
      test_stride();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
